// File: rtl/display_pkg.sv
// Shared constants and types for the two-digit multiplexed seven-segment driver.
// Segment codes are active-low, bit6..0 = g..a.
package display_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [1:0] AN_OFF  = 2'b11;

  localparam logic [6:0] SEG_CODE [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic {
    SLOT_ONES = 1'b0,
    SLOT_TENS = 1'b1
  } slot_e;

endpackage

// File: rtl/count_display_driver_if.sv
// Bundle of the counter-value inputs and the display drive outputs.
// master drives the value/config side; slave is the display driver itself.
interface count_display_driver_if;
  logic [3:0] count;
  logic [2:0] bright;
  logic       blank_lz;
  logic [1:0] an;
  logic [6:0] seg;
  logic       frame;

  modport master (output count, bright, blank_lz, input an, seg, frame);
  modport slave  (input count, bright, blank_lz, output an, seg, frame);
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment code; non-decimal inputs go dark.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (digit)
      4'd0:    seg = SEG_CODE[0];
      4'd1:    seg = SEG_CODE[1];
      4'd2:    seg = SEG_CODE[2];
      4'd3:    seg = SEG_CODE[3];
      4'd4:    seg = SEG_CODE[4];
      4'd5:    seg = SEG_CODE[5];
      4'd6:    seg = SEG_CODE[6];
      4'd7:    seg = SEG_CODE[7];
      4'd8:    seg = SEG_CODE[8];
      4'd9:    seg = SEG_CODE[9];
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/count_display_driver.sv
// Two-digit common-anode scan driver with per-frame snapshot, leading-zero
// blanking and 8-step PWM brightness. TICK_DIV must be a multiple of 8, >= 16.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   SLOT_ONES | ones digit owns the anodes for TICK_DIV cycles
//   SLOT_TENS | tens digit owns the anodes; its last cycle takes the snapshot
module count_display_driver
  import display_pkg::*;
#(
  parameter int TICK_DIV = 5000
) (
  input logic clk,
  input logic rst,
  count_display_driver_if.slave dif
);

  localparam int SUB = TICK_DIV / 8;
  localparam int PW  = $clog2(TICK_DIV);
  localparam int SW  = (SUB > 1) ? $clog2(SUB) : 1;

  logic [PW-1:0] pre;
  logic [SW-1:0] sub_cnt;
  logic [2:0]    pwm;
  logic          tick;
  logic          sub_end;

  slot_e         slot_q, slot_d;
  logic          snap;

  logic [3:0]    cnt_q;
  logic [2:0]    br_q;
  logic [3:0]    tens, ones, digit;
  logic [6:0]    seg_dec;
  logic          lit;
  logic [1:0]    an_d, an_q;
  logic [6:0]    seg_d, seg_q;
  logic          frame_q;

  assign tick    = (pre == PW'(TICK_DIV - 1));
  assign sub_end = (sub_cnt == SW'(SUB - 1));

  // pwm tracks pre / SUB without a divider; it wraps 7 -> 0 exactly at tick
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre     <= '0;
      sub_cnt <= '0;
      pwm     <= '0;
    end else if (tick) begin
      pre     <= '0;
      sub_cnt <= '0;
      pwm     <= '0;
    end else begin
      pre <= pre + 1'b1;
      if (sub_end) begin
        sub_cnt <= '0;
        pwm     <= pwm + 1'b1;
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) slot_q <= SLOT_ONES;
    else      slot_q <= slot_d;
  end

  always_comb begin
    slot_d = slot_q;
    snap   = 1'b0;
    if (tick) begin
      case (slot_q)
        SLOT_ONES: slot_d = SLOT_TENS;
        SLOT_TENS: begin
          slot_d = SLOT_ONES;
          snap   = 1'b1;
        end
        default:   slot_d = SLOT_ONES;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      br_q  <= '0;
    end else if (snap) begin
      cnt_q <= dif.count;
      br_q  <= dif.bright;
    end
  end

  assign tens  = (cnt_q >= 4'd10) ? 4'd1 : 4'd0;
  assign ones  = cnt_q - ((cnt_q >= 4'd10) ? 4'd10 : 4'd0);
  assign digit = (slot_q == SLOT_TENS) ? tens : ones;

  seg7_decode u_dec (
    .digit (digit),
    .seg   (seg_dec)
  );

  // blank_lz is deliberately live so the blanking choice responds without waiting a frame
  assign lit = (pwm < br_q) &&
               !((slot_q == SLOT_TENS) && dif.blank_lz && (tens == 4'd0));

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (lit) begin
      an_d  = (slot_q == SLOT_TENS) ? 2'b01 : 2'b10;
      seg_d = seg_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      frame_q <= 1'b0;
    end else begin
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= snap;
    end
  end

  assign dif.an    = an_q;
  assign dif.seg   = seg_q;
  assign dif.frame = frame_q;

endmodule

// File: doc/count_display_driver.md
# count_display_driver

Downstream stage of the mod-N up/down counter. Consumes the 4-bit `count` value and drives a two-digit, common-anode, time-multiplexed seven-segment display. The block converts the value to tens and ones digits, scans both digits, and supports per-frame snapshotting (no tearing), leading-zero blanking and 8-step PWM brightness.

## Interface
- `TICK_DIV`, default 5000: clock cycles per digit slot; must be a multiple of 8 and ≥ 16.
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-low; clock `clk`.
- `count` in 4: binary value to display, 0..15.
- `bright` in 3: brightness; 0 = dark, k = k/8 on-time.
- `blank_lz` in 1: 1 = blank the tens digit when it is 0.
- `an` out 2: anode enables, active-low; `an[0]` = ones, `an[1]` = tens.
- `seg` out 7: segments, active-low; `seg[0]` = a … `seg[6]` = g.
- `frame` out 1: one-cycle pulse at each frame start, i.e. on the snapshot cycle.

## Operation
- **Prescaler `pre`** counts 0..TICK_DIV-1 and wraps. `tick` = (`pre` == TICK_DIV-1).
- **Slot pointer `slot`** (0 = ones, 1 = tens) toggles on `tick`. A frame is slot 0 followed by slot 1.
- **Snapshot.** On `tick` with `slot` == 1, the block latches `count` into `cnt_q`, latches `bright` into `br_q`, and asserts `frame` on the next cycle. Input changes at any other time have no effect until the next snapshot.
- **Digit split.**
  - tens = (`cnt_q` ≥ 10) ? 1 : 0.
  - ones = `cnt_q` − 10·tens.
  - Both use 4-bit arithmetic. There is no overflow because `cnt_q` ≤ 15.
- **PWM.**
  - `pwm` is a 3-bit sub-slot index equal to `pre` / (TICK_DIV/8). It restarts at 0 with each slot.
  - The digit is lit when `pwm` < `br_q`.
  - `br_q` = 0 gives never lit; `br_q` = 7 gives lit for 7/8 of the slot. Full-on is not supported; sub-slot 7 is always dark and serves as inter-digit dead time against ghosting.
- **Blanking.** When `blank_lz` = 1 and tens = 0, the tens slot keeps `an` = 2'b11. `blank_lz` is sampled live, not snapshotted.
- **Output drive.**
  - Lit: `an` = one-hot-low for the active slot, and `seg` = decode(digit).
  - Unlit: `an` = 2'b11 and `seg` = 7'h7F.
- **Decode table** (active-low, bit6..0 = g..a):

  | Digit | Code |
  |---|---|
  | 0 | 0x40 |
  | 1 | 0x79 |
  | 2 | 0x24 |
  | 3 | 0x30 |
  | 4 | 0x19 |
  | 5 | 0x12 |
  | 6 | 0x02 |
  | 7 | 0x78 |
  | 8 | 0x00 |
  | 9 | 0x10 |

  Any other input decodes to 0x7F.

## Timing
- **Reset** (`rst` = 0 at a `clk` edge):
  - Outputs: `an` = 2'b11, `seg` = 7'h7F, `frame` = 0.
  - Internal state: `pre` = 0, `slot` = 0, `cnt_q` = 0, `br_q` = 0.
  - Reset mid-frame aborts the scan immediately, with no partial digit.
- **Registration.** `an`, `seg` and `frame` are registered: each reflects the `pre`/`slot` state of the previous cycle, giving 1 cycle of latency.
- **After reset release:**
  - The first frame is dark because `br_q` = 0.
  - The first snapshot occurs at `pre` = TICK_DIV-1 of slot 1, i.e. 2·TICK_DIV cycles after release.
  - `frame` pulses 1 cycle later.
- **Input-to-display latency.** A `count` change becomes visible between 1 and 2·TICK_DIV+1 cycles later.
- **Frame period.** `frame` pulses exactly every 2·TICK_DIV cycles.
- **Simultaneous events.** A `count` change on the snapshot cycle is captured, since it is sampled at the same edge.

## Structure
- **Package `display_pkg`** holds:
  - the SEG_CODE[0:9] constant array;
  - SEG_OFF = 7'h7F;
  - AN_OFF = 2'b11;
  - the slot enum (SLOT_ONES, SLOT_TENS).
- **Sub-module `seg7_decode`** is combinational: 4-bit digit in, 7-bit active-low segments out.
- **Top module** contains the prescaler, slot FSM, snapshot registers, PWM compare and output registers.

## Test plan
All scenarios use TICK_DIV = 16 (sub-slot = 2 cycles).
- **Reset.** Hold `rst` = 0 for 5 cycles → `an` = 11, `seg` = 7F, `frame` = 0. After release, `frame` first pulses 33 cycles later and then every 32.
- **Full brightness.** `count` = 13, `bright` = 7, `blank_lz` = 0. In the frame after a snapshot:
  - ones slot: `an` = 10, `seg` = 0x30 for 14 cycles, then 2 dark;
  - tens slot: `an` = 01, `seg` = 0x79 for 14 cycles, then 2 dark.
- **Dim and dark.** `count` = 9:
  - `bright` = 1 → each digit lit for exactly 2 of 16 cycles, with `seg` = 0x10 when ones is lit;
  - `bright` = 0 → `an` = 11 for the whole frame.
- **Leading-zero blanking.** `count` = 5, `bright` = 7:
  - `blank_lz` = 1 → the tens slot stays `an` = 11;
  - `blank_lz` = 0 → tens shows `seg` = 0x40.
- **Snapshot integrity.** Change `count` from 3 to 12 mid-frame → the display keeps showing 03 until the next `frame` pulse, then shows 12.
- **Reset mid-operation.** Assert `rst` during the tens slot with `count` = 15 → `an` = 11 on the next cycle. After release, the display is dark until the first snapshot.
